// File: rtl/pulse_narrow_pkg.sv
// Shared types and constants for the pulse narrowing receiver.
// Latency: none, types only.
// Backpressure: none, types only.
package pulse_pkg;

    typedef enum logic [1:0] {
        PN_ARM,
        PN_IDLE,
        PN_QUAL,
        PN_HIGH
    } pn_state_e;

    // Largest value an unsigned counter of cnt_w bits can hold.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/pulse_narrow_if.sv
// Bundles the level input and the event/measurement outputs of pulse_narrow.
// Latency: none, wiring only.
// Backpressure: none, outputs are strobes with no ready.
interface pulse_narrow_if #(
    parameter int CNT_W = 8
);
    logic             in;
    logic             out;
    logic [CNT_W-1:0] width;
    logic             width_vld;
    logic             ovf;

    modport master (
        output in,
        input  out,
        input  width,
        input  width_vld,
        input  ovf
    );

    modport slave (
        input  in,
        output out,
        output width,
        output width_vld,
        output ovf
    );
endinterface

// File: rtl/pulse_narrow_sync.sv
// N-flop input synchronizer; STAGES=0 passes the input straight through.
// Latency: STAGES cycles.
// Backpressure: none.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    // At least one flop exists so clk/rst are always consumed; it is dead logic when STAGES=0.
    localparam int N = (STAGES < 1) ? 1 : STAGES;

    logic [N-1:0] ff;

    // Shift the input through the flop chain, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < N; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = (STAGES == 0) ? d : ff[N-1];
endmodule

// File: rtl/pulse_narrow.sv
// Turns a level pulse into one single-cycle event and reports its high-sample length.
// Latency: out 1 cycle after the MIN_WIDTH-th high sample, width_vld 1 cycle after first low sample (+SYNC_STAGES).
// Backpressure: none; events are strobes that the consumer must take when they appear.
module pulse_narrow
    import pulse_pkg::*;
#(
    parameter int MIN_WIDTH   = 2,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 0
) (
    input  logic           clk,
    input  logic           rst,
    pulse_narrow_if.slave  bus
);
    localparam int             MAX_INT = cnt_max(CNT_W);
    localparam logic [CNT_W-1:0] CMAX  = CNT_W'(MAX_INT);
    localparam logic [CNT_W-1:0] MINW  = CNT_W'(MIN_WIDTH);

    if (MIN_WIDTH < 1 || MIN_WIDTH > MAX_INT) begin : g_bad_min
        $error("pulse_narrow: MIN_WIDTH out of range 1..2**CNT_W-1");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("pulse_narrow: SYNC_STAGES out of range 0..3");
    end

    logic             s;
    pn_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sticky, sticky_n;
    logic             out_q, out_n;
    logic             vld_q, vld_n;
    logic [CNT_W-1:0] width_q, width_n;
    logic             ovf_q, ovf_n;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.in),
        .q   (s)
    );

    // State, counter, sticky overflow and all output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PN_ARM;
            cnt     <= '0;
            sticky  <= 1'b0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            width_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sticky  <= sticky_n;
            out_q   <= out_n;
            vld_q   <= vld_n;
            width_q <= width_n;
            ovf_q   <= ovf_n;
        end
    end

    // Next-state decode: qualify, count with saturation, report on the falling sample.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sticky_n = sticky;
        out_n    = 1'b0;
        vld_n    = 1'b0;
        width_n  = width_q;
        ovf_n    = ovf_q;
        case (state)
            // A pulse already high when reset releases is ignored until it ends.
            PN_ARM: begin
                if (!s) begin
                    state_n = PN_IDLE;
                end
            end
            PN_IDLE: begin
                if (s) begin
                    cnt_n = CNT_W'(1);
                    if (MIN_WIDTH == 1) begin
                        out_n   = 1'b1;
                        state_n = PN_HIGH;
                    end else begin
                        state_n = PN_QUAL;
                    end
                end
            end
            PN_QUAL: begin
                if (s) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt + 1'b1 == MINW) begin
                        out_n   = 1'b1;
                        state_n = PN_HIGH;
                    end
                end else begin
                    // Too short: drop silently.
                    cnt_n   = '0;
                    state_n = PN_IDLE;
                end
            end
            PN_HIGH: begin
                if (s) begin
                    if (cnt == CMAX) begin
                        sticky_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    width_n  = cnt;
                    ovf_n    = sticky;
                    vld_n    = 1'b1;
                    cnt_n    = '0;
                    sticky_n = 1'b0;
                    state_n  = PN_IDLE;
                end
            end
            default: begin
                state_n = PN_ARM;
            end
        endcase
    end

    assign bus.out       = out_q;
    assign bus.width_vld = vld_q;
    assign bus.width     = width_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pulse_narrow.sv
// Directed bench for pulse_narrow across four parameter sets with an event scoreboard.
module tb_pulse_narrow;

    logic clk;
    logic rst;
    logic din [4];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // Per-instance parameters: 0 base, 1 MIN_WIDTH=1, 2 CNT_W=3, 3 SYNC_STAGES=2.
    int minw_t [4] = '{2, 1, 2, 2};
    int maxc_t [4] = '{255, 255, 7, 255};
    int sync_t [4] = '{0, 0, 0, 2};

    int last_w   [4];
    int last_ovf [4];

    typedef struct {
        int d;
        int kind;   // 0 = out, 1 = width_vld
        int cyc;
        int w;
        int ovf;
    } ev_t;

    ev_t exp_q [$];

    pulse_narrow_if #(.CNT_W(8)) if0 ();
    pulse_narrow_if #(.CNT_W(8)) if1 ();
    pulse_narrow_if #(.CNT_W(3)) if2 ();
    pulse_narrow_if #(.CNT_W(8)) if3 ();

    assign if0.in = din[0];
    assign if1.in = din[1];
    assign if2.in = din[2];
    assign if3.in = din[3];

    pulse_narrow #(.MIN_WIDTH(2), .CNT_W(8), .SYNC_STAGES(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    pulse_narrow #(.MIN_WIDTH(1), .CNT_W(8), .SYNC_STAGES(0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    pulse_narrow #(.MIN_WIDTH(2), .CNT_W(3), .SYNC_STAGES(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    pulse_narrow #(.MIN_WIDTH(2), .CNT_W(8), .SYNC_STAGES(2)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

    logic       o_out [4];
    logic       o_vld [4];
    logic       o_ovf [4];
    logic [7:0] o_w   [4];

    assign o_out[0] = if0.out;  assign o_vld[0] = if0.width_vld;  assign o_ovf[0] = if0.ovf;  assign o_w[0] = if0.width;
    assign o_out[1] = if1.out;  assign o_vld[1] = if1.width_vld;  assign o_ovf[1] = if1.ovf;  assign o_w[1] = if1.width;
    assign o_out[2] = if2.out;  assign o_vld[2] = if2.width_vld;  assign o_ovf[2] = if2.ovf;  assign o_w[2] = {5'b0, if2.width};
    assign o_out[3] = if3.out;  assign o_vld[3] = if3.width_vld;  assign o_ovf[3] = if3.ovf;  assign o_w[3] = if3.width;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Insert keeping the queue ordered by arrival cycle, then instance index.
    task automatic push_ev(input ev_t e);
        int pos;
        pos = exp_q.size();
        while (pos > 0 && (exp_q[pos-1].cyc > e.cyc ||
               (exp_q[pos-1].cyc == e.cyc && exp_q[pos-1].d > e.d))) begin
            pos--;
        end
        exp_q.insert(pos, e);
    endtask

    // Expected events for a pulse of len high cycles starting at drive cycle k.
    task automatic predict(input int d, input int k, input int len);
        ev_t e;
        if (len >= minw_t[d]) begin
            e.d = d; e.kind = 0; e.cyc = k + sync_t[d] + minw_t[d]; e.w = 0; e.ovf = 0;
            push_ev(e);
            e.kind = 1;
            e.cyc  = k + sync_t[d] + len + 1;
            e.w    = (len > maxc_t[d]) ? maxc_t[d] : len;
            e.ovf  = (len > maxc_t[d]) ? 1 : 0;
            push_ev(e);
            last_w[d]   = e.w;
            last_ovf[d] = e.ovf;
        end
    endtask

    // Raise the inputs selected by m for len cycles, starting on the next falling edge.
    task automatic drive(input logic [3:0] m, input int len);
        int k;
        @(negedge clk);
        k = cyc;
        for (int d = 0; d < 4; d++) begin
            if (m[d]) begin
                predict(d, k, len);
                din[d] = 1'b1;
            end
        end
        repeat (len) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            if (m[d]) din[d] = 1'b0;
        end
    endtask

    task automatic got(input int d, input int kind);
        ev_t e;
        string t;
        t = $sformatf("d%0d_%s@%0d", d, (kind == 0) ? "out" : "vld", cyc);
        chk({t, "_expected"}, (exp_q.size() != 0) ? 1 : 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({t, "_inst"}, d, e.d);
            chk({t, "_kind"}, kind, e.kind);
            chk({t, "_cycle"}, cyc, e.cyc);
            if (kind == 1) begin
                chk({t, "_width"}, int'(o_w[d]), e.w);
                chk({t, "_ovf"}, int'(o_ovf[d]), e.ovf);
            end
        end
    endtask

    // Observe every instance just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                if (o_out[d] === 1'b1) got(d, 0);
                if (o_vld[d] === 1'b1) got(d, 1);
            end
        end
    end

    // Wait for outstanding events, then confirm quiet outputs and held width/ovf.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (6) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s_hold_w%0d", tag, d), int'(o_w[d]), last_w[d]);
            chk($sformatf("%s_hold_ovf%0d", tag, d), int'(o_ovf[d]), last_ovf[d]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            din[d] = 1'b0;
            last_w[d] = 0;
            last_ovf[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_out%0d", d), int'(o_out[d]), 0);
            chk($sformatf("rst_vld%0d", d), int'(o_vld[d]), 0);
            chk($sformatf("rst_w%0d", d), int'(o_w[d]), 0);
            chk($sformatf("rst_ovf%0d", d), int'(o_ovf[d]), 0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic accepted pulse.
        drive(4'b0001, 6);
        drain("basic6");

        // Glitch rejected at MIN_WIDTH=2, accepted at MIN_WIDTH=1.
        drive(4'b0001, 1);
        drain("glitch_min2");
        drive(4'b0010, 1);
        drain("glitch_min1");

        // Saturation with a 3-bit counter, recovery, and the exact-max boundary.
        drive(4'b0100, 10);
        drain("sat10");
        drive(4'b0100, 3);
        drain("after_sat");
        drive(4'b0100, 7);
        drain("exact_max");
        drive(4'b0100, 8);
        drain("max_plus1");

        // Back-to-back pulses separated by a single low sample.
        drive(4'b0001, 3);
        drive(4'b0001, 3);
        drain("b2b");
        drive(4'b0010, 2);
        drive(4'b0010, 1);
        drain("b2b_min1");

        // Reset mid-pulse: no report, pulse ignored until it ends, then normal operation.
        @(negedge clk);
        din[0] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            last_w[d] = 0;
            last_ovf[d] = 0;
        end
        repeat (3) @(negedge clk);
        din[0] = 1'b0;
        drive(4'b0001, 4);
        drain("post_rst");

        // Widened strobe into the synchronized instance, alongside the direct one.
        drive(4'b1001, 4);
        drain("round_trip");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
